// File: rtl/l3_cache.sv
// l3_cache: shared last-level cache between the per-core L2 request path and
// the DRAM controller. Two-way set-associative, write-back, write-allocate,
// one outstanding request at a time.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   req_*             upstream word request (valid/ready, we, byte addr, wdata)
//   resp_valid/rdata  one-cycle response pulse; rdata holds until next response
//   mem_req_*         downstream line request: writeback (we=1) or refill (we=0)
//   mem_resp_*        refill line returned by memory (one-cycle valid)
//   hit_cnt/miss_cnt  free-running 32-bit hit and miss counters
module l3_cache #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int SETS   = 64,
   parameter int WORDS  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic [DATA_W-1:0]       req_wdata,
   output logic                    resp_valid,
   output logic [DATA_W-1:0]       resp_rdata,
   output logic                    mem_req_valid,
   input  logic                    mem_req_ready,
   output logic                    mem_req_we,
   output logic [ADDR_W-1:0]       mem_req_addr,
   output logic [DATA_W*WORDS-1:0] mem_req_wdata,
   input  logic                    mem_resp_valid,
   input  logic [DATA_W*WORDS-1:0] mem_resp_rdata,
   output logic [31:0]             hit_cnt,
   output logic [31:0]             miss_cnt
);

   localparam int LINE_W = DATA_W * WORDS;
   localparam int BYTE_B = $clog2(DATA_W / 8);
   localparam int OFF    = $clog2(WORDS * DATA_W / 8);
   localparam int WOFF_W = OFF - BYTE_B;
   localparam int IDX    = $clog2(SETS);
   localparam int TAG_W  = ADDR_W - OFF - IDX;

   typedef enum logic [2:0] {
      IDLE, LOOKUP, WRITEBACK, REFILL_REQ, REFILL_WAIT, RESPOND
   } state_t;

   state_t state;

   // Registered request
   logic              cur_we;
   logic [DATA_W-1:0] cur_wdata;
   logic [TAG_W-1:0]  cur_tag;
   logic [IDX-1:0]    cur_idx;
   logic [WOFF_W-1:0] cur_off;

   // Per-way storage; lru[set] names the way to evict next
   logic [SETS-1:0]   valid_bits [2];
   logic [SETS-1:0]   dirty_bits [2];
   logic [SETS-1:0]   lru;
   logic [TAG_W-1:0]  tag_mem  [2][SETS];
   logic [LINE_W-1:0] data_mem [2][SETS];
   logic              victim;

   logic              hit0, hit1, hit, hit_way, pick_way;
   logic [LINE_W-1:0] hit_line, pick_line, fill_line;
   logic [TAG_W-1:0]  pick_tag;
   logic              wr_hit, fill;
   logic              unused_bits;

   function automatic logic [DATA_W-1:0] get_word(input logic [LINE_W-1:0] line,
                                                  input logic [WOFF_W-1:0] off);
      logic [DATA_W-1:0] w;
      w = line[DATA_W-1:0];
      for (int i = 0; i < WORDS; i++)
         if (off == WOFF_W'(i)) w = line[i*DATA_W +: DATA_W];
      return w;
   endfunction

   function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0] line,
                                                  input logic [WOFF_W-1:0] off,
                                                  input logic [DATA_W-1:0] word);
      logic [LINE_W-1:0] res;
      res = line;
      for (int i = 0; i < WORDS; i++)
         if (off == WOFF_W'(i)) res[i*DATA_W +: DATA_W] = word;
      return res;
   endfunction

   // Byte-lane bits of the address carry no information for word accesses
   assign unused_bits = ^req_addr[BYTE_B-1:0];

   assign hit0     = valid_bits[0][cur_idx] && (tag_mem[0][cur_idx] == cur_tag);
   assign hit1     = valid_bits[1][cur_idx] && (tag_mem[1][cur_idx] == cur_tag);
   assign hit      = hit0 || hit1;
   assign hit_way  = hit1;
   assign hit_line = data_mem[hit_way][cur_idx];

   // Miss victim: an invalid way (way 0 first), otherwise the LRU way
   assign pick_way  = !valid_bits[0][cur_idx] ? 1'b0 :
                      !valid_bits[1][cur_idx] ? 1'b1 : lru[cur_idx];
   assign pick_line = data_mem[pick_way][cur_idx];
   assign pick_tag  = tag_mem[pick_way][cur_idx];

   assign wr_hit    = (state == LOOKUP) && hit && cur_we;
   assign fill      = (state == REFILL_WAIT) && mem_resp_valid;
   assign fill_line = cur_we ? put_word(mem_resp_rdata, cur_off, cur_wdata) : mem_resp_rdata;

   // Request capture and data/tag arrays (not reset)
   always_ff @(posedge clk) begin
      if (state == IDLE && req_valid && req_ready) begin
         cur_we    <= req_we;
         cur_wdata <= req_wdata;
         cur_off   <= req_addr[OFF-1:BYTE_B];
         cur_idx   <= req_addr[OFF+IDX-1:OFF];
         cur_tag   <= req_addr[ADDR_W-1:OFF+IDX];
      end
      if (!rst && wr_hit)
         data_mem[hit_way][cur_idx] <= put_word(hit_line, cur_off, cur_wdata);
      if (!rst && fill) begin
         data_mem[victim][cur_idx] <= fill_line;
         tag_mem[victim][cur_idx]  <= cur_tag;
      end
   end

   // Control FSM with registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         req_ready     <= 1'b0;
         resp_valid    <= 1'b0;
         resp_rdata    <= '0;
         mem_req_valid <= 1'b0;
         mem_req_we    <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
         hit_cnt       <= '0;
         miss_cnt      <= '0;
         valid_bits[0] <= '0;
         valid_bits[1] <= '0;
         dirty_bits[0] <= '0;
         dirty_bits[1] <= '0;
         lru           <= '0;
         victim        <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  state     <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (hit) begin
                  resp_rdata   <= cur_we ? cur_wdata : get_word(hit_line, cur_off);
                  resp_valid   <= 1'b1;
                  if (cur_we) dirty_bits[hit_way][cur_idx] <= 1'b1;
                  lru[cur_idx] <= ~hit_way;
                  hit_cnt      <= hit_cnt + 32'd1;
                  state        <= RESPOND;
               end else begin
                  miss_cnt      <= miss_cnt + 32'd1;
                  victim        <= pick_way;
                  mem_req_valid <= 1'b1;
                  if (valid_bits[pick_way][cur_idx] && dirty_bits[pick_way][cur_idx]) begin
                     mem_req_we    <= 1'b1;
                     mem_req_addr  <= {pick_tag, cur_idx, {OFF{1'b0}}};
                     mem_req_wdata <= pick_line;
                     state         <= WRITEBACK;
                  end else begin
                     mem_req_we    <= 1'b0;
                     mem_req_addr  <= {cur_tag, cur_idx, {OFF{1'b0}}};
                     state         <= REFILL_REQ;
                  end
               end
            end
            WRITEBACK: begin
               // Refill request follows back-to-back; valid stays high
               if (mem_req_ready) begin
                  mem_req_we   <= 1'b0;
                  mem_req_addr <= {cur_tag, cur_idx, {OFF{1'b0}}};
                  state        <= REFILL_REQ;
               end
            end
            REFILL_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= REFILL_WAIT;
               end
            end
            REFILL_WAIT: begin
               if (mem_resp_valid) begin
                  valid_bits[victim][cur_idx] <= 1'b1;
                  dirty_bits[victim][cur_idx] <= cur_we;
                  lru[cur_idx]                <= ~victim;
                  resp_rdata <= cur_we ? cur_wdata : get_word(mem_resp_rdata, cur_off);
                  resp_valid <= 1'b1;
                  state      <= RESPOND;
               end
            end
            RESPOND: begin
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l3_cache.sv
// tb_l3_cache: self-checking bench for l3_cache. Directed scenarios followed by
// randomized traffic, compared against an LRU-list cache model and a flat
// golden memory image; a behavioural DRAM answers the memory port.
module tb_l3_cache;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid, req_ready, req_we;
   logic [31:0]  req_addr, req_wdata;
   logic         resp_valid;
   logic [31:0]  resp_rdata;
   logic         mem_req_valid, mem_req_ready, mem_req_we;
   logic [31:0]  mem_req_addr;
   logic [127:0] mem_req_wdata;
   logic         mem_resp_valid;
   logic [127:0] mem_resp_rdata;
   logic [31:0]  hit_cnt, miss_cnt;

   always #5 clk = ~clk;

   l3_cache dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
      .mem_req_wdata(mem_req_wdata),
      .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- behavioural DRAM ----------------
   typedef struct {
      logic         we;
      logic [31:0]  addr;
      logic [127:0] wdata;
   } mreq_t;

   mreq_t        mlog[$];
   logic [127:0] dram [int unsigned];
   int           stall = 0;
   int           resp_delay = 0;
   int           resp_cnt = -1;
   int           wait_cnt = 0;
   logic [31:0]  held_addr;
   logic         held_we;
   logic [127:0] resp_line;
   time          last_mresp_t = 0;

   // Word at byte address a before any write: line 0x100 reads {4,3,2,1}
   function automatic logic [31:0] pat(input logic [31:0] a);
      return (a >> 2) - 32'h3F;
   endfunction

   function automatic logic [127:0] dram_line(input logic [31:0] la);
      logic [127:0] l;
      if (dram.exists(la)) return dram[la];
      for (int i = 0; i < 4; i++) l[i*32 +: 32] = pat(la + 32'(4*i));
      return l;
   endfunction

   initial begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;
      forever begin
         @(negedge clk);
         mem_resp_valid = 1'b0;
         if (rst) begin
            mem_req_ready = 1'b0;
            wait_cnt      = 0;
            resp_cnt      = -1;
         end else begin
            if (resp_cnt > 0) resp_cnt--;
            else if (resp_cnt == 0) begin
               mem_resp_valid = 1'b1;
               mem_resp_rdata = resp_line;
               last_mresp_t   = $time;
               resp_cnt       = -1;
            end
            if (mem_req_ready) begin
               mem_req_ready = 1'b0;
               wait_cnt      = 0;
            end else if (mem_req_valid || wait_cnt > 0) begin
               if (wait_cnt == 0) begin
                  held_addr = mem_req_addr;
                  held_we   = mem_req_we;
               end else begin
                  check("stall_valid", mem_req_valid, 1);
                  check("stall_addr", mem_req_addr, held_addr);
                  check("stall_we", mem_req_we, held_we);
               end
               if (wait_cnt < stall) wait_cnt++;
               else begin
                  mem_req_ready = 1'b1;
                  mlog.push_back('{mem_req_we, mem_req_addr, mem_req_wdata});
                  if (mem_req_we) dram[mem_req_addr] = mem_req_wdata;
                  else begin
                     resp_line = dram_line(mem_req_addr);
                     resp_cnt  = resp_delay;
                  end
               end
            end
         end
      end
   end

   // ---------------- reference model ----------------
   // Each set is an MRU-first list of up to two (tag, dirty) entries.
   int          m_cnt   [64];
   logic [21:0] m_tag   [64][2];
   bit          m_dirty [64][2];
   logic [31:0] gold [int unsigned];
   logic [31:0] exp_hits, exp_miss;

   function automatic logic [31:0] golden_word(input logic [31:0] a);
      logic [31:0]  aa;
      logic [127:0] l;
      aa = a & ~32'h3;
      if (gold.exists(aa)) return gold[aa];
      l = dram_line(aa & ~32'hF);
      return l[aa[3:2]*32 +: 32];
   endfunction

   function automatic logic [127:0] golden_line(input logic [31:0] la);
      logic [127:0] l;
      for (int i = 0; i < 4; i++) l[i*32 +: 32] = golden_word(la + 32'(4*i));
      return l;
   endfunction

   task automatic model_clear();
      for (int s = 0; s < 64; s++) m_cnt[s] = 0;
      gold.delete();
      exp_hits = 0;
      exp_miss = 0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      @(negedge clk);
      check("rst_req_ready", req_ready, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_rdata", resp_rdata, 0);
      check("rst_mem_valid", mem_req_valid, 0);
      check("rst_mem_we", mem_req_we, 0);
      check("rst_mem_addr", mem_req_addr, 0);
      check("rst_mem_wdata", mem_req_wdata, 0);
      check("rst_hit_cnt", hit_cnt, 0);
      check("rst_miss_cnt", miss_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      @(negedge clk);
      check("ready_after_rst", req_ready, 1);
   endtask

   task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      int n;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      check("req_ready", req_ready, 1);
      mlog.delete();
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      logic [5:0]   set;
      logic [21:0]  tag;
      logic [31:0]  la, exp_rd, wb_addr;
      logic [127:0] wb_data;
      bit           hit, wb, d;
      int           pos, cyc, nreq;
      set = addr[9:4];
      tag = addr[31:10];
      la  = addr & ~32'hF;
      hit = 0; pos = 0; wb = 0;
      wb_addr = '0; wb_data = '0;
      for (int i = 0; i < m_cnt[set]; i++)
         if (m_tag[set][i] == tag) begin hit = 1; pos = i; end
      exp_rd = we ? wdata : golden_word(addr);
      if (hit) begin
         d = m_dirty[set][pos] | we;
         if (pos == 1) begin
            m_tag[set][1]   = m_tag[set][0];
            m_dirty[set][1] = m_dirty[set][0];
         end
         m_tag[set][0]   = tag;
         m_dirty[set][0] = d;
         exp_hits++;
      end else begin
         if (m_cnt[set] == 2 && m_dirty[set][1]) begin
            wb      = 1;
            wb_addr = {m_tag[set][1], set, 4'h0};
            wb_data = golden_line(wb_addr);
         end
         m_tag[set][1]   = m_tag[set][0];
         m_dirty[set][1] = m_dirty[set][0];
         m_tag[set][0]   = tag;
         m_dirty[set][0] = we;
         if (m_cnt[set] < 2) m_cnt[set]++;
         exp_miss++;
      end
      if (we) gold[addr & ~32'h3] = wdata;

      drive_req(we, addr, wdata);
      cyc = 1;
      while (!resp_valid && cyc < 200) begin @(negedge clk); cyc++; end
      check("resp_seen", resp_valid, 1);
      if (hit) check("hit_latency", cyc, 2);
      else     check("miss_latency", $time - last_mresp_t, 10);
      check("resp_rdata", resp_rdata, exp_rd);
      check("hit_cnt", hit_cnt, exp_hits);
      check("miss_cnt", miss_cnt, exp_miss);
      nreq = (hit ? 0 : 1) + (wb ? 1 : 0);
      check("mem_req_count", mlog.size(), nreq);
      if (mlog.size() == nreq && nreq > 0) begin
         if (wb) begin
            check("wb_we", mlog[0].we, 1);
            check("wb_addr", mlog[0].addr, wb_addr);
            check("wb_data", mlog[0].wdata, wb_data);
         end
         check("refill_we", mlog[nreq-1].we, 0);
         check("refill_addr", mlog[nreq-1].addr, la);
      end
      @(negedge clk);
      check("resp_pulse", resp_valid, 0);
      check("ready_back", req_ready, 1);
   endtask

   task automatic reset_in_refill(input logic [31:0] addr);
      int n;
      bit saw;
      resp_delay = 8;
      drive_req(1'b0, addr, 32'h0);
      n = 0;
      while (mlog.size() == 0 && n < 50) begin @(negedge clk); n++; end
      check("rm_refill_issued", mlog.size(), 1);
      @(negedge clk);
      @(negedge clk);
      apply_reset();
      saw = 0;
      repeat (10) begin
         @(negedge clk);
         if (resp_valid) saw = 1;
      end
      check("rm_no_resp", saw, 0);
      resp_delay = 0;
   endtask

   initial begin
      logic [31:0] a, w;
      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      model_clear();
      apply_reset();

      // Directed scenarios
      do_req(1'b0, 32'h0000_0100, 32'h0);      // miss, refill {4,3,2,1}
      do_req(1'b0, 32'h0000_0104, 32'h0);      // hit
      do_req(1'b1, 32'h0000_0108, 32'hDEAD);   // write hit
      do_req(1'b0, 32'h0000_0108, 32'h0);      // read back
      do_req(1'b0, 32'h0000_0500, 32'h0);      // tag B, same set
      do_req(1'b0, 32'h0000_0904, 32'h0);      // tag C: writeback of A then refill
      do_req(1'b0, 32'h0000_0108, 32'h0);      // A back again with merged data

      stall = 5;
      do_req(1'b0, 32'h0000_2040, 32'h0);
      stall = 0;

      reset_in_refill(32'h0000_3080);
      do_req(1'b0, 32'h0000_3080, 32'h0);      // misses again after reset

      // Randomized traffic on a few crowded sets
      for (int i = 0; i < 250; i++) begin
         stall      = $urandom_range(0, 2);
         resp_delay = $urandom_range(0, 3);
         a = ($urandom_range(0, 5) << 10) | ($urandom_range(0, 3) << 4) |
             ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
         w = $urandom;
         do_req(1'($urandom_range(0, 1)), a, w);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
